// File: rtl/isa_dma_channel.sv
// Single-channel 8237-style single-transfer DMA engine bridging tx/rx byte streams to one ISA DRQ/DACK pair.
// Byte period with drq held and data ready is 1+SETUP+STROBE+HOLD clocks; tx is popped only when a write cycle starts, and no read cycle starts while rx_valid is held.
module isa_dma_channel #(
  parameter int SETUP_CYCLES  = 4,
  parameter int STROBE_CYCLES = 20,
  parameter int HOLD_CYCLES   = 4,
  parameter int COUNT_W       = 16
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               start,
  input  logic               dir,
  input  logic [COUNT_W-1:0] count,
  input  logic               abort,
  output logic               busy,
  output logic               tc,
  input  logic [7:0]         tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  input  logic               drq,
  output logic               dack_n,
  output logic               aen,
  output logic               ior_n,
  output logic               iow_n,
  output logic               isa_tc,
  output logic [7:0]         data_out,
  output logic               data_oe,
  input  logic [7:0]         data_in
);

  localparam int MAX_SH  = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int MAX_CYC = (STROBE_CYCLES > MAX_SH) ? STROBE_CYCLES : MAX_SH;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {IDLE, WAIT_DRQ, SETUP, STROBE, HOLD} state_t;

  state_t             state;
  logic [TMR_W-1:0]   tmr;
  logic [COUNT_W-1:0] remaining;
  logic               dir_q;
  logic               abort_q;
  logic               drq_meta;
  logic               drq_s;
  logic               xfer_go;
  logic               aborted;

  assign xfer_go  = (state == WAIT_DRQ) && !abort_q && drq_s && (dir_q ? !rx_valid : tx_valid);
  // Pop strobe is combinational so it coincides with the cycle the byte is latched.
  assign tx_ready = xfer_go && !dir_q;
  assign aborted  = abort_q || abort;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state     <= IDLE;
      tmr       <= '0;
      remaining <= '0;
      dir_q     <= 1'b0;
      abort_q   <= 1'b0;
      drq_meta  <= 1'b0;
      drq_s     <= 1'b0;
      busy      <= 1'b0;
      tc        <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      dack_n    <= 1'b1;
      aen       <= 1'b0;
      ior_n     <= 1'b1;
      iow_n     <= 1'b1;
      isa_tc    <= 1'b0;
      data_out  <= 8'h00;
      data_oe   <= 1'b0;
    end else begin
      drq_meta <= drq;
      drq_s    <= drq_meta;
      tc       <= 1'b0;
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;
      if (abort && state != IDLE)
        abort_q <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            remaining <= count;
            dir_q     <= dir;
            abort_q   <= 1'b0;
            busy      <= 1'b1;
            state     <= WAIT_DRQ;
          end
        end
        WAIT_DRQ: begin
          if (abort_q) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (xfer_go) begin
            tmr     <= TMR_W'(SETUP_CYCLES - 1);
            dack_n  <= 1'b0;
            aen     <= 1'b1;
            data_oe <= !dir_q;
            if (!dir_q)
              data_out <= tx_data;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (tmr == '0) begin
            tmr    <= TMR_W'(STROBE_CYCLES - 1);
            ior_n  <= !dir_q;
            iow_n  <= dir_q;
            isa_tc <= (remaining == '0);
            state  <= STROBE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        STROBE: begin
          if (tmr == '0) begin
            tmr    <= TMR_W'(HOLD_CYCLES - 1);
            ior_n  <= 1'b1;
            iow_n  <= 1'b1;
            isa_tc <= 1'b0;
            if (dir_q) begin
              rx_data  <= data_in;
              rx_valid <= 1'b1;
            end
            state  <= HOLD;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        HOLD: begin
          if (tmr == '0) begin
            dack_n  <= 1'b1;
            aen     <= 1'b0;
            data_oe <= 1'b0;
            // An abort ends the block here without tc, even on a non-final byte.
            if (remaining == '0 || aborted) begin
              tc    <= !aborted;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              remaining <= remaining - COUNT_W'(1);
              state     <= WAIT_DRQ;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_isa_dma_channel.sv
// Bench for isa_dma_channel: vector table of block transfers plus hand-written corner sequences.
module tb_isa_dma_channel;
  localparam int SETUP  = 4;
  localparam int STROBE = 20;
  localparam int HOLD   = 4;
  localparam int PERIOD = 1 + SETUP + STROBE + HOLD;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n, start, dir, abort, tx_valid, rx_ready, drq;
  logic [15:0] count;
  logic [7:0]  tx_data, data_in;
  logic        busy, tc, tx_ready, rx_valid, dack_n, aen, ior_n, iow_n, isa_tc, data_oe;
  logic [7:0]  rx_data, data_out;

  isa_dma_channel #(.SETUP_CYCLES(SETUP), .STROBE_CYCLES(STROBE), .HOLD_CYCLES(HOLD), .COUNT_W(16)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .start(start), .dir(dir), .count(count),
    .abort(abort), .busy(busy), .tc(tc), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .drq(drq), .dack_n(dack_n), .aen(aen),
    .ior_n(ior_n), .iow_n(iow_n), .isa_tc(isa_tc), .data_out(data_out), .data_oe(data_oe), .data_in(data_in)
  );

  always #5 clk_clk = ~clk_clk;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  logic [7:0] tx_src[$], rd_src[$], exp_wr[$], exp_rd[$];
  int falls[$];
  logic tc_flags[$];
  int tc_cnt, dack_falls, isa_tc_cyc;
  int fall_t, rise_t, dack_fall_t;
  logic prev_strobe_n = 1'b1, prev_ior_n = 1'b1, prev_dack_n = 1'b1, prev_rx_valid = 1'b0;
  logic pop_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic clear_stats();
    falls.delete();
    tc_flags.delete();
    tc_cnt = 0;
    dack_falls = 0;
    isa_tc_cyc = 0;
  endtask

  task automatic start_block(input logic d, input logic [15:0] c);
    start = 1'b1;
    dir   = d;
    count = c;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      if (!busy) break;
      tick();
    end
    chk("idle_reached", busy, 0);
  endtask

  // tx source: pop after the DUT has latched the byte it acknowledged
  always @(negedge clk_clk) if (tx_ready) pop_pend = 1'b1;
  always @(posedge clk_clk) begin
    #1;
    if (pop_pend && tx_src.size() > 0) void'(tx_src.pop_front());
    pop_pend = 1'b0;
    tx_valid = (tx_src.size() > 0);
    tx_data  = (tx_src.size() > 0) ? tx_src[0] : 8'h00;
  end

  // Bus monitor and scoreboard
  always @(negedge clk_clk) begin
    logic sn;
    logic [7:0] e;
    cyc++;
    sn = iow_n & ior_n;
    if (reset_reset_n) begin
      if (prev_strobe_n && !sn) begin
        falls.push_back(cyc);
        tc_flags.push_back(isa_tc);
        chk("setup_len", cyc - dack_fall_t, SETUP);
        fall_t = cyc;
        if (!iow_n) begin
          e = 'x;
          if (exp_wr.size() > 0) e = exp_wr.pop_front();
          chk("wr_data", data_out, e);
          chk("wr_oe", data_oe, 1);
        end
      end
      if (!prev_strobe_n && sn) begin
        chk("strobe_width", cyc - fall_t, STROBE);
        rise_t = cyc;
        if (!prev_ior_n && rd_src.size() > 0) void'(rd_src.pop_front());
      end
      if (prev_dack_n && !dack_n) begin
        dack_falls++;
        dack_fall_t = cyc;
      end
      if (!prev_dack_n && dack_n) chk("hold_len", cyc - rise_t, HOLD);
      if (rx_valid && !prev_rx_valid) begin
        e = 'x;
        if (exp_rd.size() > 0) e = exp_rd.pop_front();
        chk("rd_data", rx_data, e);
      end
      if (tc) tc_cnt++;
      if (isa_tc) isa_tc_cyc++;
    end
    prev_strobe_n = sn;
    prev_ior_n    = ior_n;
    prev_dack_n   = dack_n;
    prev_rx_valid = rx_valid;
    data_in = (rd_src.size() > 0) ? rd_src[0] : 8'h00;
  end

  typedef struct {
    logic        dir;
    logic [15:0] count;
    logic [23:0] d;
    int          exp_strobes;
    int          exp_tc;
  } vec_t;

  initial begin
    vec_t vt[5];
    int   nb, flag_sum;
    vt[0] = '{dir: 1'b0, count: 16'd2, d: 24'h332211, exp_strobes: 3, exp_tc: 1};
    vt[1] = '{dir: 1'b0, count: 16'd0, d: 24'h00005C, exp_strobes: 1, exp_tc: 1};
    vt[2] = '{dir: 1'b1, count: 16'd2, d: 24'h993CC3, exp_strobes: 3, exp_tc: 1};
    vt[3] = '{dir: 1'b1, count: 16'd0, d: 24'h00007E, exp_strobes: 1, exp_tc: 1};
    vt[4] = '{dir: 1'b0, count: 16'd1, d: 24'h00FF00, exp_strobes: 2, exp_tc: 1};

    reset_reset_n = 1'b0; start = 1'b0; dir = 1'b0; count = '0; abort = 1'b0;
    rx_ready = 1'b1; drq = 1'b0;
    clear_stats();
    fall_t = 0; rise_t = 0; dack_fall_t = 0;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", busy, 0);      chk("rst_tc", tc, 0);
    chk("rst_tx_ready", tx_ready, 0); chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0); chk("rst_data_out", data_out, 0);
    chk("rst_data_oe", data_oe, 0); chk("rst_aen", aen, 0);
    chk("rst_isa_tc", isa_tc, 0);   chk("rst_dack_n", dack_n, 1);
    chk("rst_ior_n", ior_n, 1);     chk("rst_iow_n", iow_n, 1);
    reset_reset_n = 1'b1;
    drq = 1'b1;
    abort = 1'b1;
    repeat (3) tick();
    abort = 1'b0;
    chk("idle_abort_noop", busy, 0);

    // Table-driven block transfers
    foreach (vt[r]) begin
      clear_stats();
      nb = int'(vt[r].count) + 1;
      for (int i = 0; i < nb; i++) begin
        if (vt[r].dir) begin
          rd_src.push_back(vt[r].d[i*8 +: 8]);
          exp_rd.push_back(vt[r].d[i*8 +: 8]);
        end else begin
          tx_src.push_back(vt[r].d[i*8 +: 8]);
          exp_wr.push_back(vt[r].d[i*8 +: 8]);
        end
      end
      tick();
      start_block(vt[r].dir, vt[r].count);
      chk("busy_after_start", busy, 1);
      wait_idle();
      tick();
      chk("strobe_count", falls.size(), vt[r].exp_strobes);
      chk("tc_pulses", tc_cnt, vt[r].exp_tc);
      chk("isa_tc_cycles", isa_tc_cyc, STROBE);
      flag_sum = 0;
      foreach (tc_flags[k]) flag_sum += int'(tc_flags[k]);
      chk("isa_tc_count", flag_sum, 1);
      chk("isa_tc_last", tc_flags.size() > 0 ? tc_flags[$] : 1'b0, 1);
      for (int k = 1; k < falls.size(); k++) chk("byte_period", falls[k] - falls[k-1], PERIOD);
      chk("sb_drained", exp_wr.size() + exp_rd.size(), 0);
      chk("aen_idle", aen, 0);
    end

    // Read with consumer stalled: second DACK must be withheld
    clear_stats();
    rx_ready = 1'b0;
    rd_src.push_back(8'hA5); rd_src.push_back(8'h5A);
    exp_rd.push_back(8'hA5); exp_rd.push_back(8'h5A);
    start_block(1'b1, 16'd1);
    for (int i = 0; i < 200; i++) begin
      if (rx_valid) break;
      tick();
    end
    chk("rx_valid_first", rx_valid, 1);
    repeat (60) tick();
    chk("rx_stall_dack", dack_falls, 1);
    chk("rx_stall_held", rx_valid, 1);
    chk("rx_stall_data", rx_data, 8'hA5);
    chk("rx_stall_busy", busy, 1);
    rx_ready = 1'b1;
    wait_idle();
    tick();
    chk("rx_second_data", rx_data, 8'h5A);
    chk("rx_tc", tc_cnt, 1);
    chk("rx_strobes", falls.size(), 2);

    // drq dropped after byte 1 of 2, then re-raised
    clear_stats();
    tx_src.push_back(8'h01); tx_src.push_back(8'h02);
    exp_wr.push_back(8'h01); exp_wr.push_back(8'h02);
    start_block(1'b0, 16'd1);
    for (int i = 0; i < 100; i++) begin
      if (!iow_n) break;
      tick();
    end
    drq = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (dack_n) break;
      tick();
    end
    repeat (40) tick();
    chk("drq_low_dack_n", dack_n, 1);
    chk("drq_low_dacks", dack_falls, 1);
    chk("drq_low_busy", busy, 1);
    drq = 1'b1;
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      nb++;
      if (!dack_n) break;
    end
    chk("drq_to_dack", nb, 3);
    wait_idle();
    tick();
    chk("drq_tc", tc_cnt, 1);

    // abort mid-strobe of byte 1 of 3
    clear_stats();
    tx_src.push_back(8'hA1); tx_src.push_back(8'hA2); tx_src.push_back(8'hA3);
    exp_wr.push_back(8'hA1); exp_wr.push_back(8'hA2); exp_wr.push_back(8'hA3);
    start_block(1'b0, 16'd2);
    for (int i = 0; i < 100; i++) begin
      if (!iow_n) break;
      tick();
    end
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle();
    repeat (60) tick();
    chk("abort_strobes", falls.size(), 1);
    chk("abort_no_tc", tc_cnt, 0);
    chk("abort_dacks", dack_falls, 1);
    chk("abort_unsent", exp_wr.size(), 2);
    chk("abort_dack_n", dack_n, 1);
    tx_src.delete();
    exp_wr.delete();
    repeat (2) tick();

    // reset mid-strobe, then a normal single-byte block
    clear_stats();
    tx_src.push_back(8'h44); tx_src.push_back(8'h55); tx_src.push_back(8'h66);
    exp_wr.push_back(8'h44); exp_wr.push_back(8'h55); exp_wr.push_back(8'h66);
    start_block(1'b0, 16'd2);
    for (int i = 0; i < 100; i++) begin
      if (!iow_n) break;
      tick();
    end
    repeat (3) tick();
    reset_reset_n = 1'b0;
    tick();
    chk("mrst_iow_n", iow_n, 1);   chk("mrst_dack_n", dack_n, 1);
    chk("mrst_aen", aen, 0);       chk("mrst_data_oe", data_oe, 0);
    chk("mrst_busy", busy, 0);     chk("mrst_isa_tc", isa_tc, 0);
    tx_src.delete();
    exp_wr.delete();
    tick();
    reset_reset_n = 1'b1;
    repeat (2) tick();
    clear_stats();
    tx_src.push_back(8'h77);
    exp_wr.push_back(8'h77);
    tick();
    start_block(1'b0, 16'd0);
    wait_idle();
    tick();
    chk("post_rst_strobes", falls.size(), 1);
    chk("post_rst_tc", tc_cnt, 1);
    chk("post_rst_sb", exp_wr.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
